ifetch_queue: RTL and testbench

Instruction fetch queue between the clocked instruction memory and the IF/ID pipeline register of the 5-stage RISC-V core. It owns the fetch PC, issues one instruction-memory read per cycle while buffer credit exists, and buffers returned instructions in a small FIFO. Instructions are presented to the IF/ID register with their PC. The queue absorbs hazard stalls without re-fetching and discards all queued and in-flight instructions on a branch/jump redirect from the EX-stage branch unit.

---
 rtl/ifetch_queue.sv | 180 ++++++++++++++++++
 tb/tb_ifetch_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue between the clocked instruction
// memory and the IF/ID register. It owns the fetch PC, issues one read per
// cycle while buffer credit exists, buffers returns in a small FIFO and
// flushes everything on a branch/jump redirect.
// Optional feature macro: IFQ_BYPASS_EN (present the in-flight return
// combinationally when the FIFO is empty, saving one cycle of latency).

module ifetch_queue #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INS_W-1:0]         imem_rdata,
    output logic                     if_valid,
    output logic [PC_W-1:0]          if_pc,
    output logic [INS_W-1:0]         if_instr,
    output logic [$clog2(DEPTH):0]   ifq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so count + inflight never wraps in the credit test.
    localparam int OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc_r;
    logic [PC_W-1:0]  inflight_pc_r;
    logic             inflight_r;
    logic [INS_W-1:0] buf_instr_r [DEPTH];
    logic [PC_W-1:0]  buf_pc_r    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             head_valid_s;
    logic             bypass_s;
    logic [PC_W-1:0]  head_pc_s;
    logic [INS_W-1:0] head_instr_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [OCC_W-1:0] occ_s;

    // Select the head entry: FIFO storage, or the in-flight return when bypassing.
    always_comb begin
        bypass_s     = 1'b0;
        head_valid_s = (count_r != {CNT_W{1'b0}});
        head_pc_s    = buf_pc_r[rd_ptr_r];
        head_instr_s = buf_instr_r[rd_ptr_r];
`ifdef IFQ_BYPASS_EN
        if ((count_r == {CNT_W{1'b0}}) && inflight_r) begin
            bypass_s     = 1'b1;
            head_valid_s = 1'b1;
            head_pc_s    = inflight_pc_r;
            head_instr_s = imem_rdata;
        end else begin
            bypass_s     = 1'b0;
        end
`endif
    end

    // Pop / push / issue decisions; redirect overrides everything.
    always_comb begin
        pop_s   = head_valid_s & ~stall & ~redirect;
        // A bypassed return that is consumed this cycle never enters storage.
        push_s  = inflight_r & ~redirect & ~(bypass_s & pop_s);
        // Credit counts the in-flight return and frees the slot being popped.
        occ_s   = OCC_W'(count_r) + OCC_W'(inflight_r) - OCC_W'(pop_s);
        // Reset gating keeps the request low while reset is held.
        issue_s = reset & ~redirect & (occ_s < OCC_W'(DEPTH));
    end

    // Drive the output ports; an empty head reads as an all-zero bubble.
    always_comb begin
        imem_req  = issue_s;
        imem_addr = fetch_pc_r;
        if_valid  = head_valid_s;
        ifq_count = count_r;
        if (head_valid_s) begin
            if_pc    = head_pc_s;
            if_instr = head_instr_s;
        end else begin
            if_pc    = {PC_W{1'b0}};
            if_instr = {INS_W{1'b0}};
        end
    end

    // Fetch PC and in-flight tracking; redirect reloads the PC and drops the return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r    <= {PC_W{1'b0}};
            inflight_r    <= 1'b0;
            inflight_pc_r <= {PC_W{1'b0}};
        end else if (redirect) begin
            fetch_pc_r    <= redirect_pc;
            inflight_r    <= 1'b0;
        end else if (issue_s) begin
            fetch_pc_r    <= fetch_pc_r + PC_W'(4);
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            inflight_r    <= 1'b0;
        end
    end

    // FIFO storage: the returning word and its PC are written at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr_r[i] <= {INS_W{1'b0}};
                buf_pc_r[i]    <= {PC_W{1'b0}};
            end
        end else if (push_s) begin
            buf_instr_r[wr_ptr_r] <= imem_rdata;
            buf_pc_r[wr_ptr_r]    <= inflight_pc_r;
        end else begin
            buf_instr_r[wr_ptr_r] <= buf_instr_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; a flush empties the queue in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirect) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    ifetch_queue_chk #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );

endmodule

// Checker: a push into a full queue without a simultaneous pop is an overflow.
module ifetch_queue_chk #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (push && !pop) |-> (count < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: the stimulus pushes the expected PC
// stream whenever it (re)starts fetch; a negedge monitor pops and compares
// each consumed instruction. Directed checks cover reset, latency, stall
// saturation, redirect, flush-during-stall, PC wrap and mid-run reset.
// Build with +define+IFQ_BYPASS_EN to check the bypass variant.

module tb_ifetch_queue;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata = 32'h0;
    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic [INS_W-1:0] if_instr;
    logic [2:0]       ifq_count;

    int               n_vec = 0;
    int               n_err = 0;
    logic [PC_W-1:0]  sb_q[$];
    logic [PC_W-1:0]  mon_pc;

    ifetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .ifq_count   (ifq_count)
    );

    always #5 clk = ~clk;

    // Memory image: word at address 0 is 0x00500093, others differ by address.
    function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
        return 32'h00500093 ^ {3'b000, a, 20'h00000};
    endfunction

    // Instruction memory with fixed one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word_at(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_restart(input logic [PC_W-1:0] start);
        logic [PC_W-1:0] p;
        p = start;
        sb_q.delete();
        for (int i = 0; i < 128; i++) begin
            sb_q.push_back(p);
            p = p + 9'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed head entry must be the next expected PC/word.
    always @(negedge clk) begin
        if (reset) begin
            if (if_valid && !stall && !redirect) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: got pc 0x%0h expected no instruction", if_pc);
                end else begin
                    mon_pc = sb_q.pop_front();
                    chk("if_pc", 32'(if_pc), 32'(mon_pc));
                    chk("if_instr", if_instr, word_at(mon_pc));
                end
            end else if (!if_valid) begin
                chk("idle_pc", 32'(if_pc), 32'h0);
                chk("idle_instr", if_instr, 32'h0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  found;
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 9'h000;

        // Reset state
        #2;
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_pc", 32'(if_pc), 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_count", 32'(ifq_count), 32'h0);

        // Release and first-fetch latency
        @(posedge clk); #1;
        sb_restart(9'h000);
        reset = 1'b1;
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'h1);
        chk("c0_addr", 32'(imem_addr), 32'h0);
        chk("c0_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        chk("c1_addr", 32'(imem_addr), 32'h4);
        chk("c1_valid", 32'(if_valid), 32'(BYP));
        @(negedge clk);
        chk("c2_addr", 32'(imem_addr), 32'h8);
        chk("c2_valid", 32'(if_valid), 32'h1);
        repeat (10) tick();

        // Stall held 6 cycles: head frozen, queue fills, requests stop
        stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("stall_pc", 32'(if_pc), 32'(sb_q[0]));
            chk("stall_valid", 32'(if_valid), 32'h1);
            if (i == 6) begin
                chk("stall_count", 32'(ifq_count), 32'h4);
                chk("stall_req", 32'(imem_req), 32'h0);
            end
        end
        tick();
        stall = 1'b0;
        repeat (10) tick();

        // Redirect to 0x040 with 3 queued and 1 in flight
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ifq_count == 3'd3) break;
            tick();
        end
        chk("pre_redir_count", 32'(ifq_count), 32'h3);
        redirect    = 1'b1;
        redirect_pc = 9'h040;
        stall       = 1'b0;
        sb_restart(9'h040);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_count", 32'(ifq_count), 32'h0);
        chk("redir_addr", 32'(imem_addr), 32'h040);
        chk("redir_req", 32'(imem_req), 32'h1);
        chk("redir_valid", 32'(if_valid), 32'h0);
        lat = 1;
        while (!if_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("redir_latency", 32'(lat), BYP ? 32'd2 : 32'd3);
        repeat (8) tick();

        // Redirect and stall together with a full queue: flush wins
        stall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ifq_count == 3'd4) break;
            tick();
        end
        chk("full_count", 32'(ifq_count), 32'h4);
        chk("full_req", 32'(imem_req), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 9'h100;
        sb_restart(9'h100);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(ifq_count), 32'h0);
        chk("flush_addr", 32'(imem_addr), 32'h100);
        repeat (8) tick();

        // Fetch PC wrap 0x1FC -> 0x000
        redirect    = 1'b1;
        redirect_pc = 9'h1F0;
        sb_restart(9'h1F0);
        tick();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 9'h1FC) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrap_seen", 32'(found), 32'h1);
        @(negedge clk);
        chk("wrap_addr", 32'(imem_addr), 32'h000);
        repeat (10) tick();

        // Reset mid-run with count=2 and a request in flight
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ifq_count == 3'd2) break;
            tick();
        end
        chk("pre_rst_count", 32'(ifq_count), 32'h2);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(if_valid), 32'h0);
        chk("mid_rst_pc", 32'(if_pc), 32'h0);
        chk("mid_rst_instr", if_instr, 32'h0);
        chk("mid_rst_req", 32'(imem_req), 32'h0);
        chk("mid_rst_count", 32'(ifq_count), 32'h0);
        repeat (2) tick();
        stall = 1'b0;
        sb_restart(9'h000);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req", 32'(imem_req), 32'h1);
        chk("rel_addr", 32'(imem_addr), 32'h0);
        chk("rel_valid", 32'(if_valid), 32'h0);
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
